johnson_decoder: RTL

//   Receive-side companion of the team's 4-bit Johnson (twisted-ring) counter: registers a

---
 rtl/johnson_decoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/johnson_decoder.sv
// johnson_decoder: registers a Johnson (twisted-ring) code sample, decodes it to a
// step index, flags illegal codes and out-of-sequence steps, and tracks lock once
// a clean run of successor steps has been observed.
//
// Handshake: code_in is consumed on every rising clk edge where code_valid is high.
// There is no back-pressure. Every output is registered, so the response to a
// sample appears one cycle after the edge that consumed it.
module johnson_decoder #(
  parameter int N        = 4,
  parameter int LOCK_LEN = 4,
  localparam int IW      = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [N-1:0]  code_in,
  input  logic          code_valid,
  output logic [IW-1:0] index_out,
  output logic          index_valid,
  output logic          illegal,
  output logic          seq_err,
  output logic          locked,
  output logic [7:0]    err_count
);

  // The "locked" output exposes this state directly, so it can serve as the state debug view.
  typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic          index_valid_q, index_valid_d;
  logic          illegal_q, illegal_d;
  logic          seq_err_q, seq_err_d;
  logic          have_prev_q, have_prev_d;
  logic [7:0]    run_q, run_d;
  logic [7:0]    err_q, err_d;

  logic          dec_legal;
  logic [IW-1:0] dec_idx;
  logic [IW-1:0] succ_idx;
  logic          is_step;
  logic          is_err;

  // Code with the k lowest bits set: the first half of the Johnson cycle.
  function automatic logic [N-1:0] lsb_ones(input int k);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (i < k);
    return r;
  endfunction

  // Code with the p highest bits set: the second half of the Johnson cycle.
  function automatic logic [N-1:0] msb_ones(input int p);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (i >= N - p);
    return r;
  endfunction

  // Decode the sample: match it against the 2N legal Johnson codes.
  always_comb begin
    dec_legal = 1'b0;
    dec_idx   = '0;
    for (int k = 0; k <= N; k++) begin
      if (code_in == lsb_ones(k)) begin
        dec_legal = 1'b1;
        dec_idx   = IW'(k);
      end
    end
    for (int p = 1; p < N; p++) begin
      if (code_in == msb_ones(p)) begin
        dec_legal = 1'b1;
        dec_idx   = IW'(2 * N - p);
      end
    end
  end

  // Expected successor of the last legal index; 2N-1 wraps back to 0.
  always_comb begin
    if (index_q == IW'(2 * N - 1)) succ_idx = '0;
    else                           succ_idx = index_q + IW'(1);
  end

  // Per-sample classification: hold, successor step or sequence error.
  always_comb begin
    index_d       = index_q;
    index_valid_d = 1'b0;
    illegal_d     = 1'b0;
    seq_err_d     = 1'b0;
    have_prev_d   = have_prev_q;
    run_d         = run_q;
    is_step       = 1'b0;
    is_err        = 1'b0;
    if (code_valid) begin
      if (!dec_legal) begin
        illegal_d = 1'b1;
        run_d     = '0;
        is_err    = 1'b1;
      end else begin
        index_valid_d = 1'b1;
        index_d       = dec_idx;
        if (!have_prev_q) begin
          // First sample after reset has no history to compare against.
          have_prev_d = 1'b1;
          run_d       = '0;
        end else if (dec_idx == index_q) begin
          // Stalled counter: no change to run length.
          run_d = run_q;
        end else if (dec_idx == succ_idx) begin
          is_step = 1'b1;
          run_d   = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
        end else begin
          seq_err_d = 1'b1;
          run_d     = '0;
          is_err    = 1'b1;
        end
      end
    end
  end

  // Saturating error counter: sticks at 255.
  always_comb begin
    err_d = err_q;
    if (is_err && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  // FSM next state: lock on the step that reaches LOCK_LEN, drop lock on any error.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACQUIRE: if (is_step && (run_d >= 8'(LOCK_LEN))) state_d = LOCKED;
      LOCKED:  if (is_err) state_d = ACQUIRE;
      default: state_d = ACQUIRE;
    endcase
  end

  // FSM and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= ACQUIRE;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      have_prev_q   <= 1'b0;
      run_q         <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      index_valid_q <= index_valid_d;
      illegal_q     <= illegal_d;
      seq_err_q     <= seq_err_d;
      have_prev_q   <= have_prev_d;
      run_q         <= run_d;
      err_q         <= err_d;
    end
  end

  // FSM output decode and register-to-port mapping.
  always_comb begin
    locked      = (state_q == LOCKED);
    index_out   = index_q;
    index_valid = index_valid_q;
    illegal     = illegal_q;
    seq_err     = seq_err_q;
    err_count   = err_q;
  end

endmodule
